// File: rtl/ob_pkg.sv
// Order-book shared types: command encoding, conditional-command helpers
// and the conditional issue arbiter state encoding.
package ob_pkg;

  localparam int unsigned OP_W = 4;
  localparam int unsigned ID_W = 12;

  // Opcode bit 3 marks a conditional (stop) form; clearing it yields the
  // executable opcode.
  localparam logic [OP_W-1:0] OP_NOP       = 4'h0;
  localparam logic [OP_W-1:0] OP_BUY       = 4'h1;
  localparam logic [OP_W-1:0] OP_SELL      = 4'h2;
  localparam logic [OP_W-1:0] OP_CANCEL    = 4'h3;
  localparam logic [OP_W-1:0] OP_STOP_BUY  = 4'h9;
  localparam logic [OP_W-1:0] OP_STOP_SELL = 4'hA;

  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [ID_W-1:0] id;
  } cmd_t;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    DRAINED = 2'd2
  } cn_arb_st_t;

  // Conditional commands are parked in the conditional table, never issued.
  function automatic logic is_cn(input cmd_t c);
    return c.op[3];
  endfunction

  // Rewrite a matured conditional command into its executable form.
  function automatic cmd_t cn_to_exec(input cmd_t c);
    cmd_t r;
    r       = c;
    r.op[3] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/ob_cn_issue_pri.sv
// Matured-vs-ingress priority with a bounded starvation counter.
// Matured commands win until STARVE_MAX consecutive wins against a waiting
// ingress command, then ingress gets one grant and the count restarts.
module ob_cn_issue_pri
  #(parameter int unsigned STARVE_MAX = 4)
  (
    input  logic       m_i,
    input  logic       i_i,
    input  logic [3:0] starve_cnt_i,
    output logic       gnt_m_o,
    output logic       gnt_i_o,
    output logic [3:0] starve_cnt_o
  );

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  // Pick one winner and compute the next starvation count.
  always_comb begin
    gnt_m_o      = 1'b0;
    gnt_i_o      = 1'b0;
    starve_cnt_o = 4'd0;
    if (m_i && i_i) begin
      if (starve_cnt_i < SMAX) begin
        gnt_m_o      = 1'b1;
        starve_cnt_o = starve_cnt_i + 4'd1;
      end else begin
        gnt_i_o      = 1'b1;
        starve_cnt_o = 4'd0;
      end
    end else if (m_i) begin
      gnt_m_o = 1'b1;
    end else if (i_i) begin
      gnt_i_o = 1'b1;
    end else begin
      starve_cnt_o = 4'd0;
    end
  end

endmodule

// File: rtl/ob_cn_issue_arb.sv
// Command issue arbiter for the order-book controller. Steers ingress stop
// commands into the conditional table, arbitrates the single issue register
// between matured and ingress commands, and quiesces on drain requests.
module ob_cn_issue_arb
  import ob_pkg::*;
  #(parameter int unsigned STARVE_MAX = 4)
  (
    input  logic clk,
    input  logic rst,
    input  logic in_vld,
    input  cmd_t in_cmd,
    output logic in_accept,
    input  logic cn_full_r,
    output logic cn_cmd_vld_r,
    output cmd_t cn_cmd_r,
    input  logic mtr_vld_r,
    input  cmd_t mtr_r,
    output logic mtr_accept,
    output logic iss_vld_r,
    output cmd_t iss_cmd_r,
    input  logic iss_accept,
    input  logic drain_req,
    output logic drained_r
  );

  cn_arb_st_t st_q;
  logic [3:0] starve_q;
  logic [3:0] starve_d;
  logic       run_s;
  logic       in_is_cn_s;
  logic       iss_free_s;
  logic       cn_acc_s;
  logic       m_s;
  logic       i_s;
  logic       gnt_m_s;
  logic       gnt_i_s;
  logic       drain_done_s;

  // Request qualification; cn_cmd_vld_r gates allocation because the
  // table's full flag trails an allocation by one cycle.
  always_comb begin
    run_s        = (st_q == RUN);
    in_is_cn_s   = is_cn(in_cmd);
    iss_free_s   = ~iss_vld_r | iss_accept;
    cn_acc_s     = run_s & in_vld & in_is_cn_s & ~cn_full_r & ~cn_cmd_vld_r;
    m_s          = iss_free_s & mtr_vld_r;
    i_s          = iss_free_s & in_vld & ~in_is_cn_s & run_s;
    drain_done_s = ~mtr_vld_r & ~iss_vld_r & ~cn_cmd_vld_r;
  end

  ob_cn_issue_pri #(.STARVE_MAX(STARVE_MAX)) u_pri (
    .m_i          (m_s),
    .i_i          (i_s),
    .starve_cnt_i (starve_q),
    .gnt_m_o      (gnt_m_s),
    .gnt_i_o      (gnt_i_s),
    .starve_cnt_o (starve_d)
  );

  assign in_accept  = cn_acc_s | gnt_i_s;
  assign mtr_accept = gnt_m_s;

  // Starvation counter advances only when the issue slot can take a command.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= 4'd0;
    end else if (iss_free_s) begin
      starve_q <= starve_d;
    end else begin
      starve_q <= starve_q;
    end
  end

  // Issue register: load on any grant, empty when consumed with no refill.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iss_vld_r <= 1'b0;
      iss_cmd_r <= '0;
    end else if (gnt_m_s) begin
      iss_vld_r <= 1'b1;
      iss_cmd_r <= cn_to_exec(mtr_r);
    end else if (gnt_i_s) begin
      iss_vld_r <= 1'b1;
      iss_cmd_r <= in_cmd;
    end else if (iss_accept) begin
      iss_vld_r <= 1'b0;
    end else begin
      iss_vld_r <= iss_vld_r;
    end
  end

  // Conditional-table allocation: single-cycle pulse carrying the command.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cn_cmd_vld_r <= 1'b0;
      cn_cmd_r     <= '0;
    end else if (cn_acc_s) begin
      cn_cmd_vld_r <= 1'b1;
      cn_cmd_r     <= in_cmd;
    end else begin
      cn_cmd_vld_r <= 1'b0;
    end
  end

  // Drain FSM with registered drained flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q      <= RUN;
      drained_r <= 1'b0;
    end else begin
      case (st_q)
        RUN: begin
          drained_r <= 1'b0;
          if (drain_req) begin
            st_q <= DRAIN;
          end else begin
            st_q <= RUN;
          end
        end
        DRAIN, DRAINED: begin
          if (!drain_req) begin
            st_q      <= RUN;
            drained_r <= 1'b0;
          end else if (drain_done_s) begin
            st_q      <= DRAINED;
            drained_r <= 1'b1;
          end else begin
            st_q      <= DRAIN;
            drained_r <= 1'b0;
          end
        end
        default: begin
          st_q      <= RUN;
          drained_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ob_cn_issue_arb.sv
// Scoreboard bench for ob_cn_issue_arb: directed scenarios push expected
// issued/allocated commands; a negedge monitor pops and compares on handshakes.
module tb_ob_cn_issue_arb;
  import ob_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic in_vld;
  cmd_t in_cmd;
  logic in_accept;
  logic cn_full_r;
  logic cn_cmd_vld_r;
  cmd_t cn_cmd_r;
  logic mtr_vld_r;
  cmd_t mtr_r;
  logic mtr_accept;
  logic iss_vld_r;
  cmd_t iss_cmd_r;
  logic iss_accept;
  logic drain_req;
  logic drained_r;

  ob_cn_issue_arb #(.STARVE_MAX(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_vld       (in_vld),
    .in_cmd       (in_cmd),
    .in_accept    (in_accept),
    .cn_full_r    (cn_full_r),
    .cn_cmd_vld_r (cn_cmd_vld_r),
    .cn_cmd_r     (cn_cmd_r),
    .mtr_vld_r    (mtr_vld_r),
    .mtr_r        (mtr_r),
    .mtr_accept   (mtr_accept),
    .iss_vld_r    (iss_vld_r),
    .iss_cmd_r    (iss_cmd_r),
    .iss_accept   (iss_accept),
    .drain_req    (drain_req),
    .drained_r    (drained_r)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  cmd_t in_q[$];
  cmd_t m_q[$];
  cmd_t exp_iss[$];
  cmd_t exp_cn[$];
  cmd_t mon_e;
  cmd_t mon_c;
  logic acc_in, acc_m, smp_cn, smp_dr;
  logic [3:0] max_starve;
  logic [6:0] pat;
  logic [5:0] drp;

  function automatic cmd_t mk(input logic [3:0] op, input logic [11:0] id);
    cmd_t c;
    c.op = op;
    c.id = id;
    return c;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One bus cycle: present queue heads, sample accepts, pop on acceptance.
  task automatic cycle();
    in_vld    = (in_q.size() > 0);
    in_cmd    = in_vld ? in_q[0] : '0;
    mtr_vld_r = (m_q.size() > 0);
    mtr_r     = mtr_vld_r ? m_q[0] : '0;
    @(negedge clk);
    acc_in = in_accept;
    acc_m  = mtr_accept;
    smp_cn = cn_cmd_vld_r;
    smp_dr = drained_r;
    @(posedge clk);
    if (acc_in) void'(in_q.pop_front());
    if (acc_m)  void'(m_q.pop_front());
    #1;
  endtask

  // Monitor: compare every issue handshake and every table allocation.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (iss_vld_r && iss_accept) begin
        if (exp_iss.size() == 0) begin
          checks++; errors++;
          $display("FAIL iss_unexpected: got 0x%0h expected none", iss_cmd_r);
        end else begin
          mon_e = exp_iss.pop_front();
          chk("iss_cmd", 32'(iss_cmd_r), 32'(mon_e));
        end
      end
      if (cn_cmd_vld_r) begin
        if (exp_cn.size() == 0) begin
          checks++; errors++;
          $display("FAIL cn_unexpected: got 0x%0h expected none", cn_cmd_r);
        end else begin
          mon_c = exp_cn.pop_front();
          chk("cn_cmd", 32'(cn_cmd_r), 32'(mon_c));
        end
      end
      if (dut.starve_q > max_starve) max_starve = dut.starve_q;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; in_vld = 1'b0; in_cmd = '0; cn_full_r = 1'b0;
    mtr_vld_r = 1'b0; mtr_r = '0; iss_accept = 1'b0; drain_req = 1'b0;
    max_starve = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_iss_vld", 32'(iss_vld_r), 32'd0);
    chk("rst_cn_vld", 32'(cn_cmd_vld_r), 32'd0);
    chk("rst_drained", 32'(drained_r), 32'd0);
    chk("rst_in_acc", 32'(in_accept), 32'd0);
    chk("rst_mtr_acc", 32'(mtr_accept), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Starvation: mtr x4, ingress, mtr x4, ingress.
    iss_accept = 1'b1;
    for (int k = 0; k < 8; k++) m_q.push_back(mk((k % 2 == 0) ? 4'h9 : 4'hA, 12'(16 + k)));
    in_q.push_back(mk(4'h1, 12'h100));
    in_q.push_back(mk(4'h2, 12'h101));
    for (int k = 0; k < 4; k++) exp_iss.push_back(mk((k % 2 == 0) ? 4'h1 : 4'h2, 12'(16 + k)));
    exp_iss.push_back(mk(4'h1, 12'h100));
    for (int k = 4; k < 8; k++) exp_iss.push_back(mk((k % 2 == 0) ? 4'h1 : 4'h2, 12'(16 + k)));
    exp_iss.push_back(mk(4'h2, 12'h101));
    max_starve = 4'd0;
    for (int n = 0; n < 30 && (m_q.size() > 0 || in_q.size() > 0); n++) cycle();
    cycle(); cycle();
    chk("starve_peak", 32'(max_starve), 32'd4);
    chk("t2_exp_left", 32'(exp_iss.size()), 32'd0);

    // Three back-to-back conditional ingress commands.
    for (int k = 0; k < 3; k++) begin
      in_q.push_back(mk((k == 1) ? 4'hA : 4'h9, 12'(12'h200 + k)));
      exp_cn.push_back(mk((k == 1) ? 4'hA : 4'h9, 12'(12'h200 + k)));
    end
    for (int c = 0; c < 7; c++) begin
      cycle();
      pat[c] = smp_cn;
    end
    chk("cn_pulse_pattern", 32'(pat), 32'(7'b0101010));
    chk("t3_exp_left", 32'(exp_cn.size()), 32'd0);

    // Table full: conditional ingress stalls, matured keeps issuing.
    cn_full_r = 1'b1;
    in_q.push_back(mk(4'h9, 12'h300));
    for (int k = 0; k < 10; k++) begin
      m_q.push_back(mk(4'hA, 12'(12'h20 + k)));
      exp_iss.push_back(mk(4'h2, 12'(12'h20 + k)));
    end
    for (int c = 0; c < 10; c++) begin
      cycle();
      chk("full_in_acc", 32'(acc_in), 32'd0);
      chk("full_mtr_acc", 32'(acc_m), 32'd1);
    end
    cn_full_r = 1'b0;
    exp_cn.push_back(mk(4'h9, 12'h300));
    cycle(); cycle(); cycle();
    chk("t4_cn_left", 32'(exp_cn.size()), 32'd0);
    chk("t4_iss_left", 32'(exp_iss.size()), 32'd0);

    // Issue backpressure: everything holds.
    iss_accept = 1'b0;
    for (int k = 0; k < 5; k++) m_q.push_back(mk(4'h9, 12'(12'h30 + k)));
    in_q.push_back(mk(4'h2, 12'h400));
    for (int k = 0; k < 4; k++) exp_iss.push_back(mk(4'h1, 12'(12'h30 + k)));
    exp_iss.push_back(mk(4'h2, 12'h400));
    exp_iss.push_back(mk(4'h1, 12'h34));
    cycle();
    for (int c = 0; c < 5; c++) begin
      cycle();
      chk("stall_in_acc", 32'(acc_in), 32'd0);
      chk("stall_mtr_acc", 32'(acc_m), 32'd0);
      chk("stall_iss_cmd", 32'(iss_cmd_r), 32'(mk(4'h1, 12'h30)));
      chk("stall_starve", 32'(dut.starve_q), 32'd1);
    end
    iss_accept = 1'b1;
    for (int n = 0; n < 30 && (m_q.size() > 0 || in_q.size() > 0); n++) cycle();
    cycle(); cycle();
    chk("t5_iss_left", 32'(exp_iss.size()), 32'd0);

    // Drain with two matured commands and a waiting ingress command.
    drain_req = 1'b1;
    m_q.push_back(mk(4'h9, 12'h40));
    m_q.push_back(mk(4'hA, 12'h41));
    in_q.push_back(mk(4'h1, 12'h500));
    exp_iss.push_back(mk(4'h1, 12'h40));
    exp_iss.push_back(mk(4'h2, 12'h41));
    for (int c = 0; c < 6; c++) begin
      cycle();
      chk("drain_in_acc", 32'(acc_in), 32'd0);
      drp[c] = smp_dr;
    end
    chk("drained_timing", 32'(drp), 32'(6'b110000));
    chk("t6_iss_left", 32'(exp_iss.size()), 32'd0);
    drain_req = 1'b0;
    exp_iss.push_back(mk(4'h1, 12'h500));
    cycle();
    chk("undrain_hold_in", 32'(acc_in), 32'd0);
    cycle();
    chk("undrain_drained", 32'(smp_dr), 32'd0);
    chk("undrain_in_acc", 32'(acc_in), 32'd1);
    cycle();
    chk("t6b_iss_left", 32'(exp_iss.size()), 32'd0);

    // Asynchronous reset with both output registers loaded.
    iss_accept = 1'b0;
    in_q.push_back(mk(4'h9, 12'h600));
    m_q.push_back(mk(4'h9, 12'h50));
    cycle();
    chk("pre_rst_in_acc", 32'(acc_in), 32'd1);
    chk("pre_rst_mtr_acc", 32'(acc_m), 32'd1);
    chk("pre_rst_iss_vld", 32'(iss_vld_r), 32'd1);
    chk("pre_rst_cn_vld", 32'(cn_cmd_vld_r), 32'd1);
    in_vld = 1'b0;
    mtr_vld_r = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    chk("arst_iss_vld", 32'(iss_vld_r), 32'd0);
    chk("arst_cn_vld", 32'(cn_cmd_vld_r), 32'd0);
    chk("arst_iss_cmd", 32'(iss_cmd_r), 32'd0);
    chk("arst_drained", 32'(drained_r), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    iss_accept = 1'b1;
    in_q.push_back(mk(4'h1, 12'h700));
    exp_iss.push_back(mk(4'h1, 12'h700));
    cycle();
    chk("post_rst_run_acc", 32'(acc_in), 32'd1);
    cycle(); cycle();
    chk("end_iss_left", 32'(exp_iss.size()), 32'd0);
    chk("end_cn_left", 32'(exp_cn.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
